// File: rtl/bmult28x28_acc.sv
// Frame accumulator for 56-bit multiplier products.
// Sums terms per frame and queues results in a 2-entry FIFO.
module bmult28x28_acc #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [55:0]      in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             busy,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] mem_sum [2];
  logic [CNT_W-1:0] mem_cnt [2];
  logic             mem_ovf [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;

  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] acc_n;
  logic [CNT_W-1:0] cnt_n;
  logic             ovf_n;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;

  always_comb begin
    acc_base = (state == IDLE) ? '0 : acc;
    sum_full = {1'b0, acc_base}
             + {{(ACC_W - 55){1'b0}}, in_p};
    acc_n    = sum_full[ACC_W-1:0];
    ovf_n    = ((state == IDLE) ? 1'b0 : ovf)
             | sum_full[ACC_W];
    if (state == IDLE)
      cnt_n = CNT_W'(1);
    else if (cnt == CNT_MAX)
      cnt_n = cnt;
    else
      cnt_n = cnt + CNT_W'(1);
  end

  assign push    = in_valid & in_last;
  assign pop     = out_valid & out_ready;
  assign full    = (occ == 2'd2);
  // A full FIFO still accepts when the head leaves this cycle.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      err        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_sum[i] <= '0;
        mem_cnt[i] <= '0;
        mem_ovf[i] <= 1'b0;
      end
    end else begin
      if (in_valid) begin
        acc <= acc_n;
        cnt <= cnt_n;
        ovf <= ovf_n;
        unique case (state)
          IDLE: if (!in_last) state <= ACC;
          ACC:  if (in_last)  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      if (push_ok) begin
        mem_sum[wr_ptr] <= acc_n;
        mem_cnt[wr_ptr] <= cnt_n;
        mem_ovf[wr_ptr] <= ovf_n;
        wr_ptr          <= ~wr_ptr;
      end
      if (push & full & ~pop)
        err <= 1'b1;
      if (pop)
        rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push_ok}
                 - {1'b0, pop};
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_sum   = mem_sum[rd_ptr];
  assign out_cnt   = mem_cnt[rd_ptr];
  assign out_ovf   = mem_ovf[rd_ptr];
  assign busy      = (state == ACC);

endmodule

// File: tb/tb_bmult28x28_acc.sv
// Self-checking bench for bmult28x28_acc.
// Directed frames plus a randomized run against a queue model.
module tb_bmult28x28_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [55:0] in_p = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_sum;
  logic [15:0] out_cnt;
  logic        out_ovf;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [55:0] PMAX = 56'hFF_FFFF_FFFF_FFFF;

  bmult28x28_acc #(.ACC_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_p(in_p),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cnt(out_cnt),
    .out_ovf(out_ovf), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    int          c;
    logic        o;
  } res_t;

  task automatic tick(input logic v,
                      input logic [55:0] p,
                      input logic l);
    in_valid = v;
    in_p     = p;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_p = 56'd5;
    in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, busy, err, out_ovf} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 0000",
               {out_valid, busy, err, out_ovf});
    end
    n_cmp++;
    if (out_sum !== 64'd0 || out_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_data got %h/%0d want 0/0",
               out_sum, out_cnt);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    tick(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ignore got v=%b b=%b want 0 0",
               out_valid, busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    tick(1'b1, 56'd1, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    tick(1'b1, 56'd2, 1'b0);
    tick(1'b1, 56'd3, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== 64'd6 ||
        out_cnt !== 16'd3 || out_ovf !== 1'b0 ||
        busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic got v=%b s=%0d c=%0d o=%b b=%b want 1 6 3 0 0",
               out_valid, out_sum, out_cnt, out_ovf, busy);
    end
    out_ready = 1'b1;
    tick(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pop got %b want 0", out_valid);
    end
  endtask

  task automatic test_single_max();
    do_reset();
    tick(1'b1, PMAX, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 ||
        out_sum !== 64'h00FF_FFFF_FFFF_FFFF ||
        out_cnt !== 16'd1 || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL single_max got v=%b s=%h c=%0d o=%b want 1 00ffffffffffffff 1 0",
               out_valid, out_sum, out_cnt, out_ovf);
    end
  endtask

  task automatic test_ovf();
    do_reset();
    for (int i = 1; i <= 257; i++)
      tick(1'b1, PMAX, (i == 257));
    n_cmp++;
    if (out_valid !== 1'b1 ||
        out_sum !== 64'h00FF_FFFF_FFFF_FEFF ||
        out_cnt !== 16'd257 || out_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf got v=%b s=%h c=%0d o=%b want 1 00fffffffffffeff 257 1",
               out_valid, out_sum, out_cnt, out_ovf);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    tick(1'b1, 56'd5, 1'b1);
    tick(1'b1, 56'd6, 1'b1);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_err_early got %b want 0", err);
    end
    tick(1'b1, 56'd7, 1'b1);
    n_cmp++;
    if (err !== 1'b1 || out_sum !== 64'd5) begin
      n_bad++;
      $display("FAIL drop_err got e=%b s=%0d want 1 5",
               err, out_sum);
    end
    out_ready = 1'b1;
    tick(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== 64'd6) begin
      n_bad++;
      $display("FAIL drop_second got v=%b s=%0d want 1 6",
               out_valid, out_sum);
    end
    tick(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_empty got v=%b e=%b want 0 1",
               out_valid, err);
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    tick(1'b1, 56'd5, 1'b1);
    tick(1'b1, 56'd6, 1'b1);
    out_ready = 1'b1;
    tick(1'b1, 56'd9, 1'b1);
    n_cmp++;
    if (err !== 1'b0 || out_valid !== 1'b1 ||
        out_sum !== 64'd6) begin
      n_bad++;
      $display("FAIL pp_full got e=%b v=%b s=%0d want 0 1 6",
               err, out_valid, out_sum);
    end
    tick(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== 64'd9) begin
      n_bad++;
      $display("FAIL pp_next got v=%b s=%0d want 1 9",
               out_valid, out_sum);
    end
    tick(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL pp_empty got v=%b e=%b want 0 0",
               out_valid, err);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    tick(1'b1, 56'd8, 1'b0);
    tick(1'b1, 56'd8, 1'b0);
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst got v=%b b=%b want 0 0",
               out_valid, busy);
    end
    tick(1'b1, 56'd4, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== 64'd4 ||
        out_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL mid_new got v=%b s=%0d c=%0d want 1 4 1",
               out_valid, out_sum, out_cnt);
    end
    out_ready = 1'b1;
    tick(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_extra got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    res_t         q[$];
    res_t         r;
    logic [127:0] total;
    int           count;
    logic         in_frame;
    logic         m_err;
    logic         v, l, rdy, pop;
    logic [63:0]  w;
    do_reset();
    total = '0;
    count = 0;
    in_frame = 1'b0;
    m_err = 1'b0;
    for (int k = 0; k < 800; k++) begin
      v   = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      w   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        w[55:0] = PMAX;
      pop = (q.size() != 0) && rdy;
      if (v) begin
        if (!in_frame) begin
          total = '0;
          count = 0;
        end
        total = total + {72'd0, w[55:0]};
        count++;
        in_frame = !l;
      end
      r.s = total[63:0];
      r.c = (count > 65535) ? 65535 : count;
      r.o = (total[127:64] != 0);
      if (pop)
        void'(q.pop_front());
      if (v && l) begin
        if (q.size() == 2 && !pop)
          m_err = 1'b1;
        else
          q.push_back(r);
      end
      out_ready = rdy;
      tick(v, w[55:0], l);
      n_cmp++;
      if (out_valid !== (q.size() != 0) ||
          busy !== in_frame || err !== m_err) begin
        n_bad++;
        $display("FAIL rnd_flags k=%0d got v=%b b=%b e=%b want %b %b %b",
                 k, out_valid, busy, err,
                 (q.size() != 0), in_frame, m_err);
      end
      if (q.size() != 0) begin
        n_cmp++;
        if (out_sum !== q[0].s ||
            out_cnt !== 16'(q[0].c) ||
            out_ovf !== q[0].o) begin
          n_bad++;
          $display("FAIL rnd_head k=%0d got %h/%0d/%b want %h/%0d/%b",
                   k, out_sum, out_cnt, out_ovf,
                   q[0].s, q[0].c, q[0].o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_max();
    test_ovf();
    test_full_drop();
    test_push_pop_full();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
